// File: rtl/evr_sequence_recorder_pkg.sv
// Shared definitions for the EVR sequence recorder: CSR command codes,
// end-of-table code, FSM encoding and status bit positions.
package evr_seq_pkg;

    typedef enum logic [1:0] {
        CMD_CTRL     = 2'd0,
        CMD_READ     = 2'd1,
        CMD_START_EV = 2'd2,
        CMD_FILTER   = 2'd3
    } csr_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_RECORDING = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    localparam logic [7:0] END_OF_TABLE_EVENT_CODE = 8'h7F;

    localparam int CTRL_ARM_BIT    = 0;
    localparam int CTRL_DISARM_BIT = 1;
    localparam int CTRL_CLEAR_BIT  = 2;
    localparam int READ_SEL_BIT    = 24;

    localparam int STAT_ARMED_BIT   = 16;
    localparam int STAT_REC_BIT     = 17;
    localparam int STAT_DONE_BIT    = 18;
    localparam int STAT_FULL_BIT    = 19;
    localparam int STAT_GAPSAT_BIT  = 20;
    localparam int STAT_EOT_BIT     = 21;
    localparam int STAT_IGN_LSB     = 22;
    localparam int STAT_ADDRW_LSB   = 27;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/evr_sequence_recorder_if.sv
// Event stream + CSR bundle of the sequence recorder.
// master drives events/CSR and reads status/readback; slave is the recorder.
interface evr_sequence_recorder_if #(
    parameter int EVCODE_W = 8
);
    logic [EVCODE_W-1:0] evrEventTDATA;
    logic                evrEventTVALID;
    logic                evrSequenceStart;
    logic                csrStrobe;
    logic [31:0]         csrData;
    logic [31:0]         status;
    logic [31:0]         sequenceReadback;

    modport master (
        output evrEventTDATA, evrEventTVALID, evrSequenceStart,
        output csrStrobe, csrData,
        input  status, sequenceReadback
    );

    modport slave (
        input  evrEventTDATA, evrEventTVALID, evrSequenceStart,
        input  csrStrobe, csrData,
        output status, sequenceReadback
    );
endinterface

// File: rtl/evr_sequence_recorder_capture_ram.sv
// Simple dual-port capture RAM: one write port, one registered read-first
// read port. Ports: clk, we/waddr/wdata write side, raddr/rdata_q read side.
module evr_seq_capture_ram #(
    parameter int DEPTH  = 2048,
    parameter int WIDTH  = 36,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata_q
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_d;

    always_comb rdata_d = mem[raddr];

    // Non-blocking write gives read-first on a same-address collision.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= rdata_d;
    end
endmodule

// File: rtl/evr_sequence_recorder.sv
// Records the received event stream as {gap, eventCode} RAM entries.
// Ports: evrRxClk, evrRxReset (async high), bus (slave: events, CSR,
// status, sequenceReadback). Optional mask: EVR_SEQ_RECORDER_FILTER_EN.
module evr_sequence_recorder
    import evr_seq_pkg::*;
#(
    parameter int SEQUENCE_RAM_CAPACITY = 2048,
    parameter int EVENTCODE_WIDTH       = 8,
    parameter int SEQUENCE_GAP_WIDTH    = 28
) (
    input logic evrRxClk,
    input logic evrRxReset,
    evr_sequence_recorder_if.slave bus
);
    localparam int ADDR_W  = $clog2(SEQUENCE_RAM_CAPACITY);
    localparam int EV_W    = EVENTCODE_WIDTH;
    localparam int GAP_W   = SEQUENCE_GAP_WIDTH;
    localparam int ENTRY_W = GAP_W + EV_W;
    localparam logic [GAP_W-1:0] GAP_MAX  = '1;
    localparam logic [EV_W-1:0]  EOT      = EV_W'(END_OF_TABLE_EVENT_CODE);
    localparam logic [15:0]      LAST_IDX = 16'(SEQUENCE_RAM_CAPACITY - 1);
    localparam logic [31:0] STATUS_RST = {5'(ADDR_W), 27'd0};

    state_e              state_q, state_d;
    logic [15:0]         entry_count_q, entry_count_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [ADDR_W-1:0]   read_addr_q, read_addr_d;
    logic                read_sel_q, read_sel_d;
    logic [EV_W-1:0]     start_event_q, start_event_d;
    logic [7:0]          ignored_q, ignored_d;
    logic                ram_full_q, ram_full_d;
    logic                gap_sat_q, gap_sat_d;
    logic                eot_q, eot_d;
    logic [31:0]         status_q, status_d;
    logic [31:0]         readback_q, readback_d;

    csr_cmd_e cmd;
    logic do_arm, do_disarm, do_clear, arm_take;
    logic start_hit_ev, masked, ev_ok, start_take;
    logic rec_write, stop, ignore_hit, is_eot, is_last;
    logic [GAP_W-1:0]   wr_gap;
    logic [ENTRY_W-1:0] rd_data;
    logic               unused_csr;

    assign unused_csr = ^bus.csrData;
    assign cmd        = csr_cmd_e'(bus.csrData[31:30]);
    assign do_disarm  = bus.csrStrobe && cmd == CMD_CTRL
                     && bus.csrData[CTRL_DISARM_BIT];
    assign do_arm     = bus.csrStrobe && cmd == CMD_CTRL
                     && bus.csrData[CTRL_ARM_BIT] && !do_disarm;
    assign do_clear   = bus.csrStrobe && cmd == CMD_CTRL
                     && bus.csrData[CTRL_CLEAR_BIT];
    assign arm_take   = do_arm
                     && (state_q == ST_IDLE || state_q == ST_DONE);

    assign start_hit_ev = bus.evrEventTVALID && start_event_q != '0
                       && bus.evrEventTDATA == start_event_q;

`ifdef EVR_SEQ_RECORDER_FILTER_EN
    logic [2**EV_W-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (bus.csrStrobe && cmd == CMD_FILTER)
            mask_d[bus.csrData[EV_W-1:0]] = bus.csrData[8];
    end

    always_ff @(posedge evrRxClk or posedge evrRxReset) begin
        if (evrRxReset) mask_q <= '0;
        else            mask_q <= mask_d;
    end

    // End-of-table and start codes must always reach the FSM.
    assign masked = mask_q[bus.evrEventTDATA]
                 && bus.evrEventTDATA != EOT
                 && bus.evrEventTDATA != start_event_q;
`else
    assign masked = 1'b0;
`endif

    assign ev_ok = bus.evrEventTVALID && !masked;

    always_ff @(posedge evrRxClk or posedge evrRxReset) begin
        if (evrRxReset) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (do_disarm) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:      if (arm_take) state_d = ST_ARMED;
                ST_ARMED:     if (start_take)
                                  state_d = stop ? ST_DONE : ST_RECORDING;
                ST_RECORDING: if (stop) state_d = ST_DONE;
                ST_DONE:      if (arm_take) state_d = ST_ARMED;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    // The start event itself is never stored; any other event arriving
    // on the start cycle is stored with gap 0.
    always_comb begin
        start_take = state_q == ST_ARMED && !do_disarm
                  && (bus.evrSequenceStart || start_hit_ev);
        rec_write  = !do_disarm
                  && ((state_q == ST_RECORDING && ev_ok)
                   || (start_take && ev_ok && !start_hit_ev));
        wr_gap     = (state_q == ST_RECORDING) ? gap_q : '0;
        is_eot     = bus.evrEventTDATA == EOT;
        is_last    = entry_count_q == LAST_IDX;
        stop       = rec_write && (is_eot || is_last);
        ignore_hit = (state_q == ST_DONE
                      && (ev_ok || bus.evrSequenceStart))
                  || (state_q == ST_RECORDING && bus.evrSequenceStart);
    end

    evr_seq_capture_ram #(
        .DEPTH  (SEQUENCE_RAM_CAPACITY),
        .WIDTH  (ENTRY_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (evrRxClk),
        .we      (rec_write),
        .waddr   (entry_count_q[ADDR_W-1:0]),
        .wdata   ({wr_gap, bus.evrEventTDATA}),
        .raddr   (read_addr_q),
        .rdata_q (rd_data)
    );

    always_comb begin
        entry_count_d = entry_count_q;
        gap_d         = gap_q;
        read_addr_d   = read_addr_q;
        read_sel_d    = read_sel_q;
        start_event_d = start_event_q;
        ignored_d     = ignored_q;
        ram_full_d    = ram_full_q;
        gap_sat_d     = gap_sat_q;
        eot_d         = eot_q;

        if (arm_take || do_clear) begin
            ignored_d  = '0;
            ram_full_d = 1'b0;
            gap_sat_d  = 1'b0;
            eot_d      = 1'b0;
        end
        if (arm_take)  entry_count_d = '0;
        if (rec_write) entry_count_d = entry_count_q + 16'd1;
        if (rec_write && is_eot)  eot_d      = 1'b1;
        if (rec_write && is_last) ram_full_d = 1'b1;
        if (ignore_hit) ignored_d = sat_inc8(ignored_d);

        if (start_take) begin
            gap_d = '0;
        end else if (state_q == ST_RECORDING) begin
            if (rec_write)             gap_d     = '0;
            else if (gap_q == GAP_MAX) gap_sat_d = 1'b1;
            else                       gap_d     = gap_q + GAP_W'(1);
        end

        if (bus.csrStrobe && cmd == CMD_READ) begin
            read_addr_d = bus.csrData[ADDR_W-1:0];
            read_sel_d  = bus.csrData[READ_SEL_BIT];
        end
        if (bus.csrStrobe && cmd == CMD_START_EV)
            start_event_d = bus.csrData[EV_W-1:0];

        status_d = STATUS_RST;
        status_d[15:0]            = entry_count_q;
        status_d[STAT_ARMED_BIT]  = state_q == ST_ARMED;
        status_d[STAT_REC_BIT]    = state_q == ST_RECORDING;
        status_d[STAT_DONE_BIT]   = state_q == ST_DONE;
        status_d[STAT_FULL_BIT]   = ram_full_q;
        status_d[STAT_GAPSAT_BIT] = gap_sat_q;
        status_d[STAT_EOT_BIT]    = eot_q;
        status_d[STAT_IGN_LSB+:5] = ignored_q[4:0];

        readback_d = read_sel_q ? 32'(rd_data[EV_W-1:0])
                                : 32'(rd_data[ENTRY_W-1:EV_W]);
    end

    always_ff @(posedge evrRxClk or posedge evrRxReset) begin
        if (evrRxReset) begin
            entry_count_q <= '0;
            gap_q         <= '0;
            read_addr_q   <= '0;
            read_sel_q    <= 1'b0;
            start_event_q <= '0;
            ignored_q     <= '0;
            ram_full_q    <= 1'b0;
            gap_sat_q     <= 1'b0;
            eot_q         <= 1'b0;
            status_q      <= STATUS_RST;
            readback_q    <= '0;
        end else begin
            entry_count_q <= entry_count_d;
            gap_q         <= gap_d;
            read_addr_q   <= read_addr_d;
            read_sel_q    <= read_sel_d;
            start_event_q <= start_event_d;
            ignored_q     <= ignored_d;
            ram_full_q    <= ram_full_d;
            gap_sat_q     <= gap_sat_d;
            eot_q         <= eot_d;
            status_q      <= status_d;
            readback_q    <= readback_d;
        end
    end

    assign bus.status           = status_q;
    assign bus.sequenceReadback = readback_q;
endmodule
